// File: rtl/bytecode_sequencer.sv
// Bytecode-to-micro-op sequencer: looks up an opcode in a run-time programmable
// length/micro-op table and issues 1..MAX_UOPS micro-ops over a valid/ready
// handshake. Opcodes with a zero-length entry complete at once and are flagged illegal.
module bytecode_sequencer #(
  parameter int INSTR_W  = 32,
  parameter int OPCODE_W = 8,
  parameter int UOP_W    = 32,
  parameter int MAX_UOPS = 4,
  parameter int CNT_W    = $clog2(MAX_UOPS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                ready,
  input  logic [INSTR_W-1:0]  instruction_in,
  output logic [UOP_W-1:0]    uop_out,
  output logic                start_for_memory,
  input  logic                ready_for_memory,
  output logic [CNT_W-1:0]    uop_index,
  output logic                done,
  output logic                illegal,
  input  logic                cfg_we,
  input  logic                cfg_len_we,
  input  logic [OPCODE_W-1:0] cfg_opcode,
  input  logic [CNT_W-1:0]    cfg_index,
  input  logic [UOP_W-1:0]    cfg_data,
  output logic                cfg_err
);

  localparam int NUM_OPS = 2 ** OPCODE_W;
  localparam int SLOT_W  = (MAX_UOPS > 1) ? $clog2(MAX_UOPS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    ISSUE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]    len_tbl [NUM_OPS];
  logic [UOP_W-1:0]    uop_tbl [NUM_OPS][MAX_UOPS];

  logic [OPCODE_W-1:0] opcode_q;
  logic [CNT_W-1:0]    len_q;
  logic [CNT_W-1:0]    idx_q;
  logic [UOP_W-1:0]    uop_q;
  logic                cfg_err_q;

  logic [CNT_W-1:0]    len_lookup;
  logic [CNT_W-1:0]    idx_nxt;
  logic                last_uop;
  logic                cfg_idx_ok;
  logic                cfg_any;
  logic                unused_instr_bits;

  // Programmed lengths above MAX_UOPS are treated as MAX_UOPS so the index never wraps.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] raw);
    if (raw > CNT_W'(MAX_UOPS)) return CNT_W'(MAX_UOPS);
    return raw;
  endfunction

  assign len_lookup        = clamp_len(len_tbl[opcode_q]);
  assign idx_nxt           = idx_q + CNT_W'(1);
  assign last_uop          = (idx_q == (len_q - CNT_W'(1)));
  assign cfg_idx_ok        = (cfg_index < CNT_W'(MAX_UOPS));
  assign cfg_any           = cfg_we | cfg_len_we;
  assign unused_instr_bits = ^instruction_in[INSTR_W-OPCODE_W-1:0];

  assign ready             = (state == IDLE);
  assign start_for_memory  = (state == ISSUE);
  assign done              = (state == FINISH);
  assign illegal           = (state == FINISH) && (len_q == '0);
  assign uop_out           = uop_q;
  assign uop_index         = idx_q;
  assign cfg_err           = cfg_err_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = (len_lookup == '0) ? FINISH : ISSUE;
      ISSUE:   if (ready_for_memory && last_uop) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sequence registers: latched opcode, length, index, presented micro-op, config error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opcode_q  <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      uop_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_any && ((state != IDLE) || (cfg_we && !cfg_idx_ok));
      unique case (state)
        IDLE: begin
          if (start) opcode_q <= instruction_in[INSTR_W-1 -: OPCODE_W];
        end
        LOOKUP: begin
          len_q <= len_lookup;
          idx_q <= '0;
          uop_q <= uop_tbl[opcode_q][SLOT_W'(0)];
        end
        ISSUE: begin
          // Preload the next micro-op on acceptance so issue runs at one per cycle.
          if (ready_for_memory && !last_uop) begin
            idx_q <= idx_nxt;
            uop_q <= uop_tbl[opcode_q][idx_nxt[SLOT_W-1:0]];
          end
        end
        default: ;
      endcase
    end
  end

  // Micro-op and length tables; writable only while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        len_tbl[i] <= '0;
        for (int j = 0; j < MAX_UOPS; j++) uop_tbl[i][j] <= '0;
      end
    end else if (state == IDLE) begin
      if (cfg_len_we)
        len_tbl[cfg_opcode] <= cfg_data[CNT_W-1:0];
      if (cfg_we && cfg_idx_ok)
        uop_tbl[cfg_opcode][cfg_index[SLOT_W-1:0]] <= cfg_data;
    end
  end

endmodule

// File: doc/bytecode_sequencer.md
Name: bytecode_sequencer

Overview:
Parametrised bytecode-to-micro-op sequencer for the JVM bytecode core. It accepts one bytecode word from fetch and looks up its opcode in a run-time-programmable micro-op table. It then issues 1..MAX_UOPS micro-ops in order to the memory/execute stage over a start_for_memory/ready_for_memory handshake. Unlike the fixed single-micro-op decoder, the per-opcode sequence length and contents are programmable, and unprogrammed opcodes are flagged as illegal.

Parameters:
INSTR_W, 32, width of instruction_in; the opcode is the top OPCODE_W bits
OPCODE_W, 8, opcode width; the table has 2**OPCODE_W entries
UOP_W, 32, micro-op width
MAX_UOPS, 4, maximum micro-ops per opcode (>=1)
CNT_W, $clog2(MAX_UOPS+1), width of the length and index fields

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  upstream request; sampled only while ready=1
ready  output  1  high when idle and able to accept a bytecode
instruction_in  input  INSTR_W  bytecode word; captured on the accepting edge
uop_out  output  UOP_W  current micro-op; valid while start_for_memory=1
start_for_memory  output  1  micro-op valid toward memory stage
ready_for_memory  input  1  memory stage accepts uop_out this cycle
uop_index  output  CNT_W  index of the micro-op currently presented
done  output  1  one-cycle pulse when a bytecode's sequence completes
illegal  output  1  one-cycle pulse, coincident with done, for a zero-length opcode
cfg_we  input  1  write cfg_data into uop table entry [cfg_opcode][cfg_index]
cfg_len_we  input  1  write cfg_data[CNT_W-1:0] into length table entry [cfg_opcode]
cfg_opcode  input  OPCODE_W  configuration opcode address
cfg_index  input  CNT_W  configuration micro-op slot (0..MAX_UOPS-1)
cfg_data  input  UOP_W  configuration data
cfg_err  output  1  one-cycle pulse when a config write is rejected

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; ready=1.
  - start_for_memory=0, done=0, illegal=0, cfg_err=0, uop_out=0, uop_index=0.
  - All length entries = 0, i.e. every opcode is illegal until programmed. Uop entries = 0.
  - Asserting reset mid-sequence aborts it immediately; no done pulse is produced.
- States: IDLE, LOOKUP, ISSUE, FINISH (2-bit encoding).
- IDLE:
  - ready=1.
  - start=1 at an edge: latch opcode=instruction_in[INSTR_W-1 -: OPCODE_W], go to LOOKUP. ready drops on the next cycle.
- LOOKUP (1 cycle, ready=0):
  - Read len=length[opcode], clamped to MAX_UOPS if larger.
  - len=0: go to FINISH with illegal set.
  - Otherwise: clear index to 0, go to ISSUE.
- ISSUE:
  - start_for_memory=1; uop_out=table[opcode][index]; uop_index=index.
  - uop_out and uop_index are registered and stay stable until accepted.
  - An edge with ready_for_memory=1 is an acceptance.
    - If index==len-1: go to FINISH, start_for_memory=0.
    - Otherwise: index+1; the next micro-op is presented the following cycle, i.e. back-to-back issue at 1 uop/cycle when ready_for_memory is held high.
  - ready_for_memory while start_for_memory=0 is ignored.
- FINISH (1 cycle):
  - done=1; illegal=1 only if len was 0.
  - Next state IDLE; ready=1 the following cycle.
- Latency:
  - Accept edge -> first start_for_memory = 2 cycles.
  - Last acceptance -> done = 1 cycle.
  - Minimum total for len=1 with ready_for_memory held high: 4 cycles accept-to-ready.
- start while ready=0 is ignored; upstream must hold start until it sees ready.
- Configuration:
  - Writes take effect on the edge and are accepted only in IDLE.
  - In any other state, a write is dropped and cfg_err pulses for 1 cycle.
  - cfg_we with cfg_index>=MAX_UOPS is dropped with cfg_err.
  - cfg_we and cfg_len_we in the same cycle are both performed.
  - A config write and an accepting start on the same IDLE edge: the write completes first, so the lookup sees the new value.
- The index never wraps: the sequence always ends at len-1.

Test Plan:
- Reset, program length[0x60]=1 and table[0x60][0]=0x92010 4E0, start with instruction_in=0x60000000, ready_for_memory=1 -> start_for_memory high exactly 1 cycle with uop_out=0x920104E0 and uop_index=0, then done=1, illegal=0, ready=1.
- Program length[0x18]=3 with uops 0xA1,0xA2,0xA3, hold ready_for_memory=0 for 3 cycles, then assert it -> uop_out holds 0xA1 while stalled, then 0xA2 and 0xA3 on consecutive cycles, single done pulse.
- Start with unprogrammed opcode 0xFF -> no start_for_memory; done=1 and illegal=1 together, 2 cycles after accept.
- cfg_we during ISSUE, and cfg_we with cfg_index=4 (MAX_UOPS=4) while IDLE -> both dropped, cfg_err pulses each time, table unchanged on readback.
- Drive reset low mid-ISSUE at index 1 of 3 -> same cycle: start_for_memory=0, ready=1, uop_index=0, done never pulses; length table reads 0 after release.
- Program length[0x6F]=7 with MAX_UOPS=4 -> exactly 4 micro-ops issued (index 0..3), then done.
